// File: rtl/transform_param_regs_pkg.sv
// Shared definitions for the transform parameter register block:
// register indices, reset defaults and the frame-load FSM state type.
package transform_param_regs_pkg;

  localparam int DATA_W    = 25;
  localparam int ADDR_W    = 7;
  localparam int NUM_REGS  = 11;
  localparam int MEM_DEPTH = NUM_REGS * 8;
  localparam int MATRIX_W  = 9 * DATA_W;

  localparam logic [3:0] IDX_WIDTH = 4'd0;
  localparam logic [3:0] IDX_DEPTH = 4'd1;
  localparam logic [3:0] IDX_T11   = 4'd2;
  localparam logic [3:0] IDX_T12   = 4'd3;
  localparam logic [3:0] IDX_T13   = 4'd4;
  localparam logic [3:0] IDX_T21   = 4'd5;
  localparam logic [3:0] IDX_T22   = 4'd6;
  localparam logic [3:0] IDX_T23   = 4'd7;
  localparam logic [3:0] IDX_T31   = 4'd8;
  localparam logic [3:0] IDX_T32   = 4'd9;
  localparam logic [3:0] IDX_T33   = 4'd10;

  localparam int DEF_IMG_WIDTH = 320;
  localparam int DEF_IMG_DEPTH = 240;
  localparam logic [DATA_W-1:0] DEF_HALF = 25'h000800;
  localparam logic [DATA_W-1:0] DEF_ONE  = 25'h001000;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, COMMIT} load_state_t;

  // Reset matrix: T11 = T22 = 0.5, T33 = 1.0, everything else zero.
  function automatic logic [MATRIX_W-1:0] default_matrix();
    logic [MATRIX_W-1:0] m;
    m = '0;
    m[0*DATA_W +: DATA_W] = DEF_HALF;
    m[4*DATA_W +: DATA_W] = DEF_HALF;
    m[8*DATA_W +: DATA_W] = DEF_ONE;
    return m;
  endfunction

endpackage

// File: rtl/transform_param_regs_param_dpram.sv
// Simple dual-port shadow RAM: one write port, one synchronous read port.
// A read of a word written in the same cycle returns the previous contents.
module param_dpram #(
  parameter int DATA_W = 25,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 88
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (wr_addr <= LAST_ADDR)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_addr <= LAST_ADDR) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/transform_param_regs.sv
// Double-buffered camera transform parameters: writes land in a shadow RAM,
// a frame start copies one mode/camera set into the active outputs atomically.
// Optional readback port enabled by defining PARAM_READBACK_EN.
module transform_param_regs
  import transform_param_regs_pkg::*;
#(
  parameter int CAM_LINE  = 9,
  parameter int CAM_PIXEL = 10
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]    i_data,
  input  logic                 i_we,
  input  logic                 i_configured,
  input  logic [1:0]           i_mode,
  input  logic                 i_cam,
  input  logic                 i_frame_start,
  output logic [CAM_PIXEL-1:0] o_img_width,
  output logic [CAM_LINE-1:0]  o_img_depth,
  output logic [MATRIX_W-1:0]  o_matrix,
  output logic                 o_valid,
  output logic                 o_update,
  output logic                 o_addr_err
`ifdef PARAM_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [DATA_W-1:0]    o_rd_data
`endif
);

  load_state_t state_q, state_d;

  logic [3:0]        wr_idx;
  logic              wr_ok;
  logic [DATA_W-1:0] wr_word;
  logic [3:0]        load_cnt;
  logic [1:0]        mode_q;
  logic              cam_q;
  logic              rd_en;
  logic              rd_pend;
  logic [3:0]        rd_idx_q;
  logic              commit;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] stage [NUM_REGS];

  assign wr_idx    = i_addr[6:3];
  assign wr_ok     = i_we && (wr_idx <= IDX_T33);
  assign load_addr = {load_cnt, mode_q, cam_q};

  // Size fields are stored already truncated so every reader sees zero upper bits.
  always_comb begin
    wr_word = i_data;
    if (wr_idx == IDX_WIDTH) begin
      wr_word = '0;
      wr_word[CAM_PIXEL-1:0] = i_data[CAM_PIXEL-1:0];
    end else if (wr_idx == IDX_DEPTH) begin
      wr_word = '0;
      wr_word[CAM_LINE-1:0] = i_data[CAM_LINE-1:0];
    end
  end

  param_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (MEM_DEPTH)
  ) u_load_ram (
    .clk     (clk),
    .we      (wr_ok),
    .wr_addr (i_addr),
    .wr_data (wr_word),
    .rd_addr (load_addr),
    .rd_data (load_word)
  );

  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_addr_err <= 1'b0;
    end else if (i_we && (wr_idx > IDX_T33)) begin
      o_addr_err <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE:    if (i_frame_start && i_configured) state_d = LOAD;
      LOAD: begin
        rd_en = 1'b1;
        if (load_cnt == IDX_T33) state_d = WAIT;
      end
      WAIT:    state_d = COMMIT;
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      load_cnt <= '0;
      mode_q   <= '0;
      cam_q    <= 1'b0;
      rd_pend  <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_pend  <= rd_en;
      rd_idx_q <= load_cnt;
      if (state_q == IDLE && state_d == LOAD) begin
        load_cnt <= '0;
        mode_q   <= i_mode;
        cam_q    <= i_cam;
      end else if (rd_en) begin
        load_cnt <= load_cnt + 4'd1;
      end
    end
  end

  // Each word lands in staging the cycle after its RAM read returns.
  always_ff @(posedge clk) begin
    if (rd_pend) begin
      stage[rd_idx_q] <= load_word;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_img_width <= CAM_PIXEL'(DEF_IMG_WIDTH);
      o_img_depth <= CAM_LINE'(DEF_IMG_DEPTH);
      o_matrix    <= default_matrix();
      o_valid     <= 1'b0;
      o_update    <= 1'b0;
    end else begin
      o_update <= commit;
      if (commit) begin
        o_img_width <= stage[IDX_WIDTH][CAM_PIXEL-1:0];
        o_img_depth <= stage[IDX_DEPTH][CAM_LINE-1:0];
        for (int r = 0; r < 9; r++) begin
          o_matrix[r*DATA_W +: DATA_W] <= stage[r + 2];
        end
        o_valid <= 1'b1;
      end
    end
  end

`ifdef PARAM_READBACK_EN
  // A mirror RAM keeps readback fully independent of frame loads.
  logic [DATA_W-1:0] rb_word;
  logic              rb_live;

  param_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (MEM_DEPTH)
  ) u_rb_ram (
    .clk     (clk),
    .we      (wr_ok),
    .wr_addr (i_addr),
    .wr_data (wr_word),
    .rd_addr (i_rd_addr),
    .rd_data (rb_word)
  );

  always_ff @(posedge clk) begin
    if (i_reset) begin
      rb_live <= 1'b0;
    end else begin
      rb_live <= 1'b1;
    end
  end

  assign o_rd_data = rb_live ? rb_word : '0;
`endif

endmodule

// File: tb/tb_transform_param_regs.sv
// Self-checking bench for transform_param_regs: vector table, randomized
// writes/frames against a shadow-memory model, and multi-cycle corner cases.
module tb_transform_param_regs;

  localparam int CAM_LINE  = 9;
  localparam int CAM_PIXEL = 10;

  logic                 clk = 1'b0;
  logic                 i_reset;
  logic [6:0]           i_addr;
  logic [24:0]          i_data;
  logic                 i_we;
  logic                 i_configured;
  logic [1:0]           i_mode;
  logic                 i_cam;
  logic                 i_frame_start;
  logic [CAM_PIXEL-1:0] o_img_width;
  logic [CAM_LINE-1:0]  o_img_depth;
  logic [224:0]         o_matrix;
  logic                 o_valid;
  logic                 o_update;
  logic                 o_addr_err;
`ifdef PARAM_READBACK_EN
  logic [6:0]           i_rd_addr;
  logic [24:0]          o_rd_data;
`endif

  transform_param_regs #(.CAM_LINE(CAM_LINE), .CAM_PIXEL(CAM_PIXEL)) dut (
    .clk           (clk),
    .i_reset       (i_reset),
    .i_addr        (i_addr),
    .i_data        (i_data),
    .i_we          (i_we),
    .i_configured  (i_configured),
    .i_mode        (i_mode),
    .i_cam         (i_cam),
    .i_frame_start (i_frame_start),
    .o_img_width   (o_img_width),
    .o_img_depth   (o_img_depth),
    .o_matrix      (o_matrix),
    .o_valid       (o_valid),
    .o_update      (o_update),
    .o_addr_err    (o_addr_err)
`ifdef PARAM_READBACK_EN
    ,
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic [1:0]  mode;
    logic        cam;
    logic [24:0] data;
    logic [24:0] exp_word;
  } vec_t;

  int          checks = 0;
  int          passes = 0;
  logic [24:0] model_mem [88];
  bit          model_err = 0;
  logic [24:0]  last_width, last_depth;
  logic [224:0] last_matrix;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [224:0] act, input logic [224:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else passes++;
  endtask

  function automatic logic [224:0] default_matrix_exp();
    logic [224:0] m;
    m = '0;
    m[24:0]    = 25'h000800;
    m[124:100] = 25'h000800;
    m[224:200] = 25'h001000;
    return m;
  endfunction

  // What the shadow memory should hold after a write, from the field-width rules.
  function automatic logic [24:0] model_store(input int idx, input logic [24:0] data);
    if (idx == 0) return 25'(int'(data) % (1 << CAM_PIXEL));
    if (idx == 1) return 25'(int'(data) % (1 << CAM_LINE));
    return data;
  endfunction

  function automatic int word_addr(input int idx, input logic [1:0] mode, input logic cam);
    return idx * 8 + int'(mode) * 2 + int'(cam);
  endfunction

  function automatic logic [224:0] model_matrix(input logic [1:0] mode, input logic cam);
    logic [224:0] m;
    for (int r = 0; r < 9; r++) m[r*25 +: 25] = model_mem[word_addr(r + 2, mode, cam)];
    return m;
  endfunction

  task automatic applyStimulus(input logic [6:0] addr, input logic [24:0] data);
    int idx;
    i_we = 1'b1; i_addr = addr; i_data = data;
    tick();
    i_we = 1'b0;
    idx = int'(addr[6:3]);
    if (idx <= 10) model_mem[int'(addr)] = model_store(idx, data);
    else model_err = 1'b1;
  endtask

  task automatic checkOutputsHeld(input string tag);
    checkOutput({tag, "_width"}, 225'(o_img_width), 225'(last_width));
    checkOutput({tag, "_depth"}, 225'(o_img_depth), 225'(last_depth));
    checkOutput({tag, "_matrix"}, o_matrix, last_matrix);
  endtask

  // Accept one frame and check latency plus the whole committed set.
  task automatic run_frame(input logic [1:0] mode, input logic cam, input bit scramble);
    logic [224:0] em;
    logic [24:0]  ew, ed;
    int n;
    bit seen;
    em = model_matrix(mode, cam);
    ew = model_mem[word_addr(0, mode, cam)];
    ed = model_mem[word_addr(1, mode, cam)];
    i_mode = mode; i_cam = cam; i_configured = 1'b1; i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    if (scramble) begin
      i_mode = 2'($urandom);
      i_cam  = 1'($urandom);
    end
    seen = 0; n = 0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (o_update) seen = 1;
    end
    checkOutput("update_latency", 225'(n), 225'(13));
    checkOutput("img_width", 225'(o_img_width), 225'(ew));
    checkOutput("img_depth", 225'(o_img_depth), 225'(ed));
    checkOutput("matrix", o_matrix, em);
    checkOutput("valid", 225'(o_valid), 225'(1));
    last_width = ew; last_depth = ed; last_matrix = em;
    tick();
    checkOutput("update_pulse_len", 225'(o_update), 225'(0));
  endtask

  initial begin
    vec_t vecs [6];
    logic [224:0] em;
    logic [24:0]  v5, v6, got;
    int upd, first;

    vecs[0] = '{4'd0,  2'd1, 1'b0, 25'h1FFFFFF, 25'h00003FF};
    vecs[1] = '{4'd1,  2'd2, 1'b1, 25'h1ABCDEF, 25'h00001EF};
    vecs[2] = '{4'd3,  2'd2, 1'b1, 25'h1FFF000, 25'h1FFF000};
    vecs[3] = '{4'd10, 2'd3, 1'b1, 25'h0001000, 25'h0001000};
    vecs[4] = '{4'd2,  2'd0, 1'b0, 25'h0000ABC, 25'h0000ABC};
    vecs[5] = '{4'd0,  2'd3, 1'b1, 25'h0000140, 25'h0000140};

    i_reset = 1'b1; i_addr = '0; i_data = '0; i_we = 1'b0; i_configured = 1'b0;
    i_mode = '0; i_cam = 1'b0; i_frame_start = 1'b0;
`ifdef PARAM_READBACK_EN
    i_rd_addr = '0;
`endif
    repeat (3) tick();
`ifdef PARAM_READBACK_EN
    checkOutput("rd_data_reset", 225'(o_rd_data), 225'(0));
`endif
    i_reset = 1'b0;
    tick();
    $display("[TB] reset checks");
    checkOutput("reset_width", 225'(o_img_width), 225'(320));
    checkOutput("reset_depth", 225'(o_img_depth), 225'(240));
    checkOutput("reset_matrix", o_matrix, default_matrix_exp());
    checkOutput("reset_valid", 225'(o_valid), 225'(0));
    checkOutput("reset_update", 225'(o_update), 225'(0));
    checkOutput("reset_addr_err", 225'(o_addr_err), 225'(0));

    for (int a = 0; a < 88; a++) applyStimulus(7'(a), 25'($urandom));
    checkOutput("addr_err_after_fill", 225'(o_addr_err), 225'(0));

    $display("[TB] vector table");
    for (int v = 0; v < 6; v++) begin
      applyStimulus({vecs[v].idx, vecs[v].mode, vecs[v].cam}, vecs[v].data);
      run_frame(vecs[v].mode, vecs[v].cam, 1'b0);
      case (vecs[v].idx)
        4'd0:    got = 25'(o_img_width);
        4'd1:    got = 25'(o_img_depth);
        default: got = o_matrix[(int'(vecs[v].idx) - 2)*25 +: 25];
      endcase
      checkOutput("vector_field", 225'(got), 225'(vecs[v].exp_word));
    end

    $display("[TB] frame start during load");
    em = model_matrix(2'd0, 1'b1);
    i_mode = 2'd0; i_cam = 1'b1; i_frame_start = 1'b1;
    tick();
    upd = 0; first = 0;
    for (int k = 1; k <= 35; k++) begin
      i_frame_start = (k == 5);
      tick();
      if (o_update) begin
        upd++;
        if (first == 0) first = k;
      end
    end
    i_frame_start = 1'b0;
    checkOutput("double_start_pulses", 225'(upd), 225'(1));
    checkOutput("double_start_latency", 225'(first), 225'(13));
    checkOutput("double_start_matrix", o_matrix, em);
    last_width = model_mem[word_addr(0, 2'd0, 1'b1)];
    last_depth = model_mem[word_addr(1, 2'd0, 1'b1)];
    last_matrix = em;

    $display("[TB] frame start while unconfigured");
    i_configured = 1'b0; i_mode = 2'd3; i_cam = 1'b0; i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    upd = 0;
    repeat (20) begin
      tick();
      if (o_update) upd++;
    end
    checkOutput("unconfigured_pulses", 225'(upd), 225'(0));
    checkOutputsHeld("unconfigured");
    i_configured = 1'b1;

    $display("[TB] write/read collision during load");
    em = model_matrix(2'd1, 1'b0);
    v6 = ~model_mem[word_addr(6, 2'd1, 1'b0)];
    v5 = ~model_mem[word_addr(5, 2'd1, 1'b0)];
    i_mode = 2'd1; i_cam = 1'b0; i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    repeat (4) tick();
    applyStimulus({4'd6, 2'd1, 1'b0}, v6);
    applyStimulus({4'd5, 2'd1, 1'b0}, v5);
    em[4*25 +: 25] = v6;
    upd = 6; first = 0;
    while (first == 0 && upd < 40) begin
      tick();
      upd++;
      if (o_update) first = upd;
    end
    checkOutput("collision_latency", 225'(first), 225'(13));
    checkOutput("collision_matrix", o_matrix, em);
    last_matrix = em;
    run_frame(2'd1, 1'b0, 1'b0);

    $display("[TB] bad index write");
    checkOutput("addr_err_before", 225'(o_addr_err), 225'(0));
    applyStimulus(7'h58, 25'h1555555);
    checkOutput("addr_err_set", 225'(o_addr_err), 225'(1));
    repeat (3) tick();
    checkOutput("addr_err_sticky", 225'(o_addr_err), 225'(1));
    for (int m = 0; m < 8; m++) run_frame(2'(m >> 1), 1'(m), 1'b0);

`ifdef PARAM_READBACK_EN
    $display("[TB] readback");
    applyStimulus(7'h10, 25'h0000ABC);
    i_rd_addr = 7'h10;
    tick();
    checkOutput("readback", 225'(o_rd_data), 225'(25'h0000ABC));
`endif

    $display("[TB] randomized frames");
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 4)) applyStimulus(7'($urandom_range(0, 127)), 25'($urandom));
      run_frame(2'($urandom), 1'($urandom), 1'b1);
      checkOutput("random_addr_err", 225'(o_addr_err), 225'(model_err));
    end

    $display("[TB] reset during load");
    i_mode = 2'd2; i_cam = 1'b1; i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    repeat (6) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    model_err = 1'b0;
    upd = 0;
    repeat (20) begin
      tick();
      if (o_update) upd++;
    end
    checkOutput("reset_load_pulses", 225'(upd), 225'(0));
    checkOutput("reset_load_width", 225'(o_img_width), 225'(320));
    checkOutput("reset_load_depth", 225'(o_img_depth), 225'(240));
    checkOutput("reset_load_matrix", o_matrix, default_matrix_exp());
    checkOutput("reset_load_valid", 225'(o_valid), 225'(0));
    checkOutput("reset_load_addr_err", 225'(o_addr_err), 225'(0));
    run_frame(2'd2, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/transform_param_regs.md
TRANSFORM_PARAM_REGS -- requirements
Module: transform_param_regs

Interface
REQ-001 Parameters: CAM_LINE default 9, line-count field width; CAM_PIXEL default 10, pixel-count field width.
REQ-002 Reset i_reset, synchronous, active-high; clock clk.
REQ-003 clk  input  1  system clock; every flop is clocked on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_addr  input  7  write address: [6:3] register index, [2:1] mode, [0] camera.
REQ-006 i_data  input  25  write data, signed fixed point s12.12 for matrix words.
REQ-007 i_we  input  1  write strobe; one write per high cycle.
REQ-008 i_configured  input  1  level from the parameter writer: all defaults have been written.
REQ-009 i_mode  input  2  switch-selected mode; i_cam input 1 selects the camera.
REQ-010 i_frame_start  input  1  one-cycle pulse at frame boundary.
REQ-011 o_img_width  output  CAM_PIXEL; o_img_depth output CAM_LINE; o_matrix output 225, T11 in [24:0] through T33 in [224:200], row-major.
REQ-012 o_valid  output  1  active set loaded from written storage; o_update output 1, one-cycle commit pulse; o_addr_err output 1, sticky bad-index flag.

Function
REQ-013 Storage: 88 x 25-bit shadow memory indexed by i_addr; a write with i_we and index 0..10 updates the word at the next edge.
REQ-014 A write with index 11..15 is discarded and sets o_addr_err, which stays high until reset.
REQ-015 Index 0 keeps only [CAM_PIXEL-1:0] and index 1 only [CAM_LINE-1:0]; upper bits read as zero.
REQ-016 FSM states: IDLE, LOAD, WAIT, COMMIT.
REQ-017 IDLE -> LOAD on i_frame_start while i_configured=1; i_mode and i_cam are latched in the same cycle.
REQ-018 LOAD issues 11 reads, index 0..10, one per cycle; memory read latency is 1 cycle; WAIT collects the last word; COMMIT -> IDLE.
REQ-019 Read words go to a staging set; active outputs change only in COMMIT, all fields together, so there are no torn updates.
REQ-020 o_update and the new outputs appear on the edge ending COMMIT, exactly 13 cycles after the edge that sampled i_frame_start; o_valid is set at the first commit.
REQ-021 i_frame_start outside IDLE is ignored; a load is never restarted.
REQ-022 i_frame_start with i_configured=0 is ignored; outputs hold.
REQ-023 Read/write collision on the same word in the same cycle: the read returns the old data.
REQ-024 Changing i_mode or i_cam takes effect only at the next accepted frame start.

Reset
REQ-025 On reset: FSM=IDLE, o_valid=0, o_update=0, o_addr_err=0, o_img_width=320, o_img_depth=240, o_matrix = T11=T22=0.5 (0x000800), T33=1.0 (0x001000), others 0.
REQ-026 Shadow memory contents are not cleared by reset.
REQ-027 Reset mid-LOAD aborts the load; staging is discarded and no commit occurs.

Configuration
REQ-028 Macro PARAM_READBACK_EN defined: adds input i_rd_addr (7) and output o_rd_data (25), 1-cycle read latency, on a port independent of the load; reset value of o_rd_data is 0.
REQ-029 PARAM_READBACK_EN undefined: neither port exists and no readback logic is built.

Structure
REQ-030 A shared package holds the register index constants (0..10), NUM_REGS=11, the reset defaults, and the FSM state enum.
REQ-031 One sub-module, param_dpram: 88x25 simple dual-port RAM with synchronous read, one write port and one read port.

Verification
REQ-032 Reset, then read outputs -> width=320, depth=240, T11=0x000800, T33=0x001000, o_valid=0.
REQ-033 Write T12 (index 3), mode 2, cam 1, value 0x1FFF000; set i_configured=1, i_mode=2, i_cam=1; pulse i_frame_start -> 13 cycles later o_update=1 and o_matrix[49:25]=0x1FFF000.
REQ-034 Write to address 0x58 (index 11) -> o_addr_err=1 and no memory word changes.
REQ-035 Second i_frame_start 5 cycles into LOAD -> exactly one o_update pulse.
REQ-036 Assert i_reset at LOAD cycle 6 -> no o_update, outputs at defaults, and the next frame start loads normally.
REQ-037 With PARAM_READBACK_EN defined, write 0x0000ABC to address 0x10 and read it back -> o_rd_data=0x0000ABC one cycle after i_rd_addr=0x10.
